// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: rotates (x0,y0) onto the positive x axis, accumulating atan2(y0,x0) in z.
// Iterates one micro-rotation per clock after a quadrant pre-rotation on the capture edge.
module cordic_vectoring #(
   parameter int WIDTH    = 32,
   parameter int MAX_ITER = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] y0,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z,
   output logic             busy,
   output logic             done
);

   localparam int IW = $clog2(MAX_ITER + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(102944);

   // round(atan(2^-k) * 2^16); beyond k=16 the entry rounds to zero
   function automatic logic signed [WIDTH-1:0] atanEntry(input int k);
      case (k)
         0:       atanEntry = WIDTH'(51472);
         1:       atanEntry = WIDTH'(30386);
         2:       atanEntry = WIDTH'(16055);
         3:       atanEntry = WIDTH'(8150);
         4:       atanEntry = WIDTH'(4091);
         5:       atanEntry = WIDTH'(2047);
         6:       atanEntry = WIDTH'(1024);
         7:       atanEntry = WIDTH'(512);
         8:       atanEntry = WIDTH'(256);
         9:       atanEntry = WIDTH'(128);
         10:      atanEntry = WIDTH'(64);
         11:      atanEntry = WIDTH'(32);
         12:      atanEntry = WIDTH'(16);
         13:      atanEntry = WIDTH'(8);
         14:      atanEntry = WIDTH'(4);
         15:      atanEntry = WIDTH'(2);
         16:      atanEntry = WIDTH'(1);
         default: atanEntry = '0;
      endcase
   endfunction

   logic [1:0]              state_q, state_d;
   logic signed [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
   logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [IW-1:0]           i_q, i_d, ne_q, ne_d;

   logic signed [WIDTH-1:0] x0s, y0s, xShift, yShift;
   logic [IW-1:0]           neIn;

   assign x0s    = x0;
   assign y0s    = y0;
   assign xShift = xr_q >>> i_q;
   assign yShift = yr_q >>> i_q;
   assign neIn   = (n > WIDTH'(MAX_ITER)) ? IW'(MAX_ITER) : n[IW-1:0];

   always_comb begin
      state_d = state_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      zr_d    = zr_q;
      i_d     = i_q;
      ne_d    = ne_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (valid) begin
               if (!x0s[WIDTH-1]) begin
                  xr_d = x0s;
                  yr_d = y0s;
                  zr_d = '0;
               end else if (!y0s[WIDTH-1]) begin
                  xr_d = y0s;
                  yr_d = -x0s;
                  zr_d = HALF_PI;
               end else begin
                  xr_d = -y0s;
                  yr_d = x0s;
                  zr_d = -HALF_PI;
               end
               i_d  = '0;
               ne_d = neIn;
               if (neIn == '0) begin
                  state_d = DONE;
                  x_d     = xr_d;
                  y_d     = yr_d;
                  z_d     = zr_d;
               end else begin
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            if (!yr_q[WIDTH-1]) begin
               xr_d = xr_q + yShift;
               yr_d = yr_q - xShift;
               zr_d = zr_q + atanEntry(int'(i_q));
            end else begin
               xr_d = xr_q - yShift;
               yr_d = yr_q + xShift;
               zr_d = zr_q - atanEntry(int'(i_q));
            end
            i_d = i_q + IW'(1);
            // Results are published on the same edge that completes the last micro-rotation
            if (i_d == ne_q) begin
               state_d = DONE;
               x_d     = xr_d;
               y_d     = yr_d;
               z_d     = zr_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         xr_q    <= '0;
         yr_q    <= '0;
         zr_q    <= '0;
         i_q     <= '0;
         ne_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         zr_q    <= zr_d;
         i_q     <= i_d;
         ne_q    <= ne_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign z    = z_q;
   assign busy = (state_q == ITER);
   assign done = (state_q == DONE);

endmodule
